// File: rtl/st_pack_stage_if.sv
// st_pack_stage_if: handshake bundle for the width-up packer.
//   Beat side : i_vld, i_rdy, data_i[IW], i_last
//   Word side : o_vld, o_rdy, data_o[IW*RATIO], o_cnt[CW], o_last
//   slave  modport : the packer's view (consumes beats, produces words)
//   master modport : the surrounding environment's view
interface st_pack_stage_if #(
    parameter int IW    = 8,
    parameter int RATIO = 4,
    parameter int CW    = $clog2(RATIO) + 1
);
    logic                 i_vld;
    logic                 i_rdy;
    logic [IW-1:0]        data_i;
    logic                 i_last;
    logic                 o_vld;
    logic                 o_rdy;
    logic [IW*RATIO-1:0]  data_o;
    logic [CW-1:0]        o_cnt;
    logic                 o_last;

    modport slave (
        input  i_vld, data_i, i_last, o_rdy,
        output i_rdy, o_vld, data_o, o_cnt, o_last
    );

    modport master (
        output i_vld, data_i, i_last, o_rdy,
        input  i_rdy, o_vld, data_o, o_cnt, o_last
    );
endinterface

// File: rtl/st_pack_stage.sv
// st_pack_stage: valid/ready width-up packer. Collects RATIO beats of IW bits
// (or fewer when i_last closes the word early) into one IW*RATIO word held in
// a registered output slot. The accumulator keeps filling while the slot is
// stalled; only the completing beat has to wait for a free slot.
//   clk, rst : clock, synchronous active-high reset
//   bus      : st_pack_stage_if.slave (beat input side, word output side)
//
// st_pack_lane: one IW-bit lane of the accumulator plus the matching lane of
// the output slot.
//   cnt  : current lane counter of the packer
//   wr   : a non-completing beat is accepted this cycle
//   load : a completing beat is accepted this cycle (slot load)
//   beat : the incoming beat
//   word : this lane of data_o

module st_pack_lane #(
    parameter int IW   = 8,
    parameter int LANE = 0,
    parameter int CNTW = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [CNTW-1:0] cnt,
    input  logic            wr,
    input  logic            load,
    input  logic [IW-1:0]   beat,
    output logic [IW-1:0]   word
);
    localparam logic [CNTW-1:0] LANE_IDX = CNTW'(LANE);

    logic [IW-1:0] acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc  <= '0;
            word <= '0;
        end else if (load) begin
            // Lanes below cnt come from the accumulator, lane cnt from the
            // completing beat, lanes above cnt are unused in a short word.
            acc <= '0;
            if (LANE_IDX < cnt)
                word <= acc;
            else if (LANE_IDX == cnt)
                word <= beat;
            else
                word <= '0;
        end else if (wr && (cnt == LANE_IDX)) begin
            acc <= beat;
        end
    end
endmodule

module st_pack_stage #(
    parameter int IW        = 8,
    parameter int RATIO     = 4,
    parameter bit CUT_READY = 1'b0,
    parameter int CW        = $clog2(RATIO) + 1
) (
    input  logic               clk,
    input  logic               rst,
    st_pack_stage_if.slave     bus
);
    localparam int              CNTW     = $clog2(RATIO);
    localparam logic [CNTW-1:0] LAST_IDX = CNTW'(RATIO - 1);

    logic [CNTW-1:0]            cnt;
    logic                       o_vld;
    logic [CW-1:0]              o_cnt;
    logic                       o_last;
    logic [RATIO-1:0][IW-1:0]   word;

    logic at_last;
    logic slot_free;
    logic hs;
    logic done;
    logic wr;

    assign at_last   = (cnt == LAST_IDX);
    assign slot_free = CUT_READY ? ~o_vld : (~o_vld | bus.o_rdy);

    // Ready never looks at i_vld: only a completing beat needs the slot.
    assign bus.i_rdy = slot_free | (~at_last & ~bus.i_last);

    assign hs   = bus.i_vld & bus.i_rdy;
    assign done = hs & (at_last | bus.i_last);
    assign wr   = hs & ~done;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            o_vld  <= 1'b0;
            o_cnt  <= '0;
            o_last <= 1'b0;
        end else begin
            if (done)
                cnt <= '0;
            else if (hs)
                cnt <= cnt + 1'b1;

            // A load wins over a pop, so pop+load keeps o_vld high.
            if (done) begin
                o_vld  <= 1'b1;
                o_cnt  <= CW'(cnt) + 1'b1;
                o_last <= bus.i_last;
            end else if (o_vld && bus.o_rdy) begin
                o_vld <= 1'b0;
            end
        end
    end

    for (genvar g = 0; g < RATIO; g++) begin : g_lane
        st_pack_lane #(
            .IW   (IW),
            .LANE (g),
            .CNTW (CNTW)
        ) u_lane (
            .clk  (clk),
            .rst  (rst),
            .cnt  (cnt),
            .wr   (wr),
            .load (done),
            .beat (bus.data_i),
            .word (word[g])
        );
    end

    assign bus.o_vld  = o_vld;
    assign bus.data_o = word;
    assign bus.o_cnt  = o_cnt;
    assign bus.o_last = o_last;
endmodule

// File: tb/tb_st_pack_stage.sv
// tb_st_pack_stage: directed + random scoreboard bench for st_pack_stage
// (IW=8, RATIO=4). dut0 uses CUT_READY=0, dut1 uses CUT_READY=1.
module tb_st_pack_stage;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    st_pack_stage_if #(.IW(8), .RATIO(4)) b0 ();
    st_pack_stage_if #(.IW(8), .RATIO(4)) b1 ();

    st_pack_stage #(.IW(8), .RATIO(4), .CUT_READY(1'b0)) dut0 (
        .clk (clk), .rst (rst), .bus (b0)
    );
    st_pack_stage #(.IW(8), .RATIO(4), .CUT_READY(1'b1)) dut1 (
        .clk (clk), .rst (rst), .bus (b1)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [2:0]  cnt;
        logic        last;
    } word_t;

    word_t expq[$];
    word_t mon_e;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic void push(input logic [31:0] d, input logic [2:0] c, input logic l);
        expq.push_back('{data: d, cnt: c, last: l});
    endfunction

    // Monitor: pops the scoreboard on every output handshake and checks
    // that a stalled word holds still.
    logic        stall_p = 1'b0;
    logic [31:0] d_p;
    logic [2:0]  c_p;
    logic        l_p;

    always @(negedge clk) begin
        if (rst) begin
            stall_p = 1'b0;
        end else begin
            if (stall_p) begin
                chk("stall_vld",  64'(b0.o_vld),  1);
                chk("stall_data", 64'(b0.data_o), 64'(d_p));
                chk("stall_cnt",  64'(b0.o_cnt),  64'(c_p));
                chk("stall_last", 64'(b0.o_last), 64'(l_p));
            end
            if (b0.o_vld && b0.o_rdy) begin
                if (expq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_word: got %h want none", b0.data_o);
                end else begin
                    mon_e = expq.pop_front();
                    chk("word_data", 64'(b0.data_o), 64'(mon_e.data));
                    chk("word_cnt",  64'(b0.o_cnt),  64'(mon_e.cnt));
                    chk("word_last", 64'(b0.o_last), 64'(mon_e.last));
                end
            end
            stall_p = b0.o_vld && !b0.o_rdy;
            d_p     = b0.data_o;
            c_p     = b0.o_cnt;
            l_p     = b0.o_last;
        end
    end

    // Beat-level model used only in the random phase.
    logic        use_model = 1'b0;
    logic [31:0] m_acc = '0;
    int          m_cnt = 0;

    task automatic drive(input logic v, input logic [7:0] d, input logic l, input logic r,
                         output logic hs);
        @(posedge clk);
        #1;
        b0.i_vld  = v;
        b0.data_i = d;
        b0.i_last = l;
        b0.o_rdy  = r;
        @(negedge clk);
        hs = v & b0.i_rdy;
        if (hs && use_model) begin
            m_acc[m_cnt*8 +: 8] = d;
            if (m_cnt == 3 || l) begin
                push(m_acc, 3'(m_cnt + 1), l);
                m_acc = '0;
                m_cnt = 0;
            end else begin
                m_cnt++;
            end
        end
    endtask

    task automatic idle(input logic r, input int n);
        logic hs;
        for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0, r, hs);
    endtask

    task automatic send(input logic [7:0] d, input logic l, input logic r);
        logic hs;
        int   n;
        n = 0;
        do begin
            drive(1'b1, d, l, r, hs);
            n++;
        end while (!hs && n < 50);
        if (!hs) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got no handshake want handshake for beat %h", d);
        end
    endtask

    logic hs;

    initial begin
        rst = 1'b1;
        b0.i_vld = 1'b0; b0.data_i = '0; b0.i_last = 1'b0; b0.o_rdy = 1'b0;
        b1.i_vld = 1'b0; b1.data_i = '0; b1.i_last = 1'b0; b1.o_rdy = 1'b0;
        idle(1'b0, 3);
        chk("rst_vld",  64'(b0.o_vld),  0);
        chk("rst_data", 64'(b0.data_o), 0);
        chk("rst_cnt",  64'(b0.o_cnt),  0);
        chk("rst_last", 64'(b0.o_last), 0);
        chk("rst_rdy",  64'(b0.i_rdy),  1);
        rst = 1'b0;
        idle(1'b1, 2);

        // Full word back-to-back, latency of one cycle.
        push(32'h44332211, 3'd4, 1'b0);
        send(8'h11, 1'b0, 1'b1);
        send(8'h22, 1'b0, 1'b1);
        send(8'h33, 1'b0, 1'b1);
        send(8'h44, 1'b0, 1'b1);
        chk("lat_before", 64'(b0.o_vld), 0);
        idle(1'b1, 1);
        chk("lat_after", 64'(b0.o_vld), 1);
        idle(1'b1, 2);

        // Early close, then single-beat word.
        push(32'h0000BBAA, 3'd2, 1'b1);
        push(32'h000000CC, 3'd1, 1'b1);
        send(8'hAA, 1'b0, 1'b1);
        send(8'hBB, 1'b1, 1'b1);
        send(8'hCC, 1'b1, 1'b1);
        idle(1'b1, 3);

        // Backpressure: accumulate behind a stalled slot.
        push(32'h44332211, 3'd4, 1'b0);
        push(32'h88776655, 3'd4, 1'b0);
        send(8'h11, 1'b0, 1'b0);
        send(8'h22, 1'b0, 1'b0);
        send(8'h33, 1'b0, 1'b0);
        send(8'h44, 1'b0, 1'b0);
        send(8'h55, 1'b0, 1'b0);
        send(8'h66, 1'b0, 1'b0);
        send(8'h77, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 8'h88, 1'b0, 1'b0, hs);
            chk("bp_rdy_low", 64'(hs), 0);
            chk("bp_data_hold", 64'(b0.data_o), 64'h44332211);
        end
        drive(1'b1, 8'h88, 1'b0, 1'b1, hs);
        chk("bp_rdy_pop", 64'(hs), 1);
        idle(1'b1, 3);

        // i_last on every beat: one word per cycle.
        for (int k = 0; k < 6; k++) begin
            push({24'h0, 8'(8'hA0 + k)}, 3'd1, 1'b1);
            drive(1'b1, 8'(8'hA0 + k), 1'b1, 1'b1, hs);
            chk("burst_rdy", 64'(hs), 1);
            if (k > 0) chk("burst_vld", 64'(b0.o_vld), 1);
        end
        idle(1'b1, 3);

        // Reset mid-packet discards the partial word.
        send(8'h01, 1'b0, 1'b1);
        send(8'h02, 1'b0, 1'b1);
        rst = 1'b1;
        idle(1'b1, 1);
        chk("mid_rst_vld",  64'(b0.o_vld),  0);
        chk("mid_rst_data", 64'(b0.data_o), 0);
        chk("mid_rst_cnt",  64'(b0.o_cnt),  0);
        chk("mid_rst_last", 64'(b0.o_last), 0);
        rst = 1'b0;
        push(32'h06050403, 3'd4, 1'b0);
        send(8'h03, 1'b0, 1'b1);
        send(8'h04, 1'b0, 1'b1);
        send(8'h05, 1'b0, 1'b1);
        send(8'h06, 1'b0, 1'b1);
        idle(1'b1, 3);
        chk("directed_drain", 64'(expq.size()), 0);

        // Random traffic against the beat-level model.
        use_model = 1'b1;
        m_acc = '0;
        m_cnt = 0;
        for (int i = 0; i < 10000; i++)
            drive(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 3) != 0), hs);
        drive(1'b0, 8'h00, 1'b0, 1'b1, hs);
        use_model = 1'b0;
        idle(1'b1, 6);
        chk("random_drain", 64'(expq.size()), 0);

        // CUT_READY=1 instance: i_last on every beat gives one word per 2 cycles.
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            b1.i_vld  = 1'b1;
            b1.data_i = 8'(k);
            b1.i_last = 1'b1;
            b1.o_rdy  = 1'b1;
            @(negedge clk);
            chk("cut1_rdy", 64'(b1.i_rdy), 64'(k % 2 == 0));
            chk("cut1_vld", 64'(b1.o_vld), 64'(k % 2 == 1));
            if (k % 2 == 1) begin
                chk("cut1_data", 64'(b1.data_o), 64'(k - 1));
                chk("cut1_cnt",  64'(b1.o_cnt),  1);
            end
        end
        b1.i_vld = 1'b0;
        idle(1'b1, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
